// File: rtl/param_memory_pkg.sv
// Shared definitions for the parametrised data memory family.
// Holds FSM state encodings, default geometry and an index-width helper.
// Register file and instruction memory reuse the same default constants.
package param_memory_pkg;

    // Controller states: storage is being zeroed, or serving requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

    // Default geometry shared across the datapath memories.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    // Bits needed to index DEPTH words; at least 1 so a one-word memory still has a port.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Purpose: DEPTH x DATA_W storage with one write port and one synchronous read port on a shared address.
// Latency: 1 edge for reads and writes; rdata holds when no read is requested.
// Backpressure: none; every enabled access completes at the edge it is sampled.
module mem_array
    import param_memory_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WRITE_FIRST = 1,
    parameter int IDX_W       = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: storage itself is never reset, only overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: same-edge write either forwards new data or exposes the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            if ((WRITE_FIRST != 0) && we) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/param_memory.sv
// Purpose: single-port data memory with hardware clear after reset, range check and read/err strobes.
// Latency: 1 edge read and write; clear takes DEPTH edges after reset before requests are accepted.
// Backpressure: busy is high during clear and requests are silently dropped; no other stalls.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WRITE_FIRST = 1
) (
    input  logic              power,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              busy,
    output logic              err
);

    localparam int              IDX_W    = idx_width(DEPTH);
    // DEPTH held one bit wider than the address so DEPTH = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    mem_state_t        state;
    logic [IDX_W-1:0]  clr_cnt;

    logic              in_range;
    logic              clearing;
    logic              accept;
    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Unsigned compare using every address bit; constant-true when DEPTH fills the address space.
    assign in_range  = ({1'b0, add} < DEPTH_V);
    // A reset edge must leave storage untouched, so both paths are gated by reset.
    assign clearing  = !reset && (state == ST_CLEAR);
    assign accept    = !reset && (state == ST_READY) && in_range;

    // Clear sequence borrows the single storage port; user requests only reach it when ready.
    assign mem_we    = clearing || (accept && write);
    assign mem_re    = accept && read;
    assign mem_addr  = clearing ? clr_cnt : add[IDX_W-1:0];
    assign mem_wdata = clearing ? '0 : data_in;

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WRITE_FIRST (WRITE_FIRST),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk   (power),
        .rst   (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (data_out)
    );

    // Controller FSM: walks the clear counter, then produces registered valid/err strobes.
    always_ff @(posedge power) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    valid   <= 1'b0;
                    err     <= 1'b0;
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    busy  <= 1'b0;
                    valid <= read && in_range;
                    err   <= (read || write) && !in_range;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: three instances (default/write-first, DEPTH=200/read-first, 16x16).
// Stimulus feeds a word-array reference model that pushes expected outputs into a scoreboard queue.
// A negedge monitor pops every expectation and compares it with the matching instance.
module tb_param_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        wr  [3];
    logic        rd  [3];
    logic [7:0]  ad  [3];
    logic [15:0] di  [3];

    logic [7:0]  dout0, dout1;
    logic [15:0] dout2;
    logic        v0, v1, v2, b0, b1, b2, e0, e1, e2;

    param_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WRITE_FIRST(1)) u0 (
        .power(clk), .reset(rst[0]), .write(wr[0]), .read(rd[0]), .add(ad[0]),
        .data_in(di[0][7:0]), .data_out(dout0), .valid(v0), .busy(b0), .err(e0));

    param_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WRITE_FIRST(0)) u1 (
        .power(clk), .reset(rst[1]), .write(wr[1]), .read(rd[1]), .add(ad[1]),
        .data_in(di[1][7:0]), .data_out(dout1), .valid(v1), .busy(b1), .err(e1));

    param_memory #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .WRITE_FIRST(1)) u2 (
        .power(clk), .reset(rst[2]), .write(wr[2]), .read(rd[2]), .add(ad[2][3:0]),
        .data_in(di[2]), .data_out(dout2), .valid(v2), .busy(b2), .err(e2));

    // Instance geometry as seen by the model.
    int DWV  [3] = '{8, 8, 16};
    int AWV  [3] = '{8, 8, 4};
    int DEPV [3] = '{256, 200, 16};
    int WFV  [3] = '{1, 0, 1};

    // Reference model state: word contents, clear progress, last read data.
    int unsigned mm    [3][256];
    bit          mbusy [3];
    int          mcnt  [3];
    int unsigned mdout [3];

    typedef struct {
        int          idx;
        bit          v;
        bit          e;
        bit          b;
        int unsigned d;
    } exp_t;

    exp_t sbq[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, i, act, expv, $time);
        end
    endtask

    // Behavioural effect of one clock edge on instance i, recorded as an expectation.
    task automatic model_step(input int i);
        int unsigned a;
        int unsigned d;
        exp_t        x;
        a = int'(ad[i]) & ((1 << AWV[i]) - 1);
        d = int'(di[i]) & ((1 << DWV[i]) - 1);
        x.idx = i;
        x.v = 1'b0;
        x.e = 1'b0;
        if (rst[i]) begin
            mbusy[i] = 1'b1;
            mcnt[i]  = 0;
            mdout[i] = 0;
        end else if (mbusy[i]) begin
            mm[i][mcnt[i]] = 0;
            mcnt[i]++;
            if (mcnt[i] == DEPV[i]) mbusy[i] = 1'b0;
        end else if ((rd[i] || wr[i]) && (a >= DEPV[i])) begin
            x.e = 1'b1;
        end else begin
            if (rd[i]) begin
                mdout[i] = (wr[i] && WFV[i] != 0) ? d : mm[i][a];
                x.v = 1'b1;
            end
            if (wr[i]) mm[i][a] = d;
        end
        x.b = mbusy[i];
        x.d = mdout[i];
        sbq.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
    endtask

    task automatic req_all(input bit w, input bit r, input int a, input int d);
        for (int i = 0; i < 3; i++) begin
            wr[i] = w;
            rd[i] = r;
            ad[i] = 8'(a);
            di[i] = 16'(d);
        end
        tick();
    endtask

    // Monitor: compare every pending expectation against its instance, away from the active edge.
    always @(negedge clk) begin
        exp_t        x;
        logic [15:0] od;
        logic        ov, oe, ob;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            case (x.idx)
                0:       begin od = {8'h00, dout0}; ov = v0; oe = e0; ob = b0; end
                1:       begin od = {8'h00, dout1}; ov = v1; oe = e1; ob = b1; end
                default: begin od = dout2;          ov = v2; oe = e2; ob = b2; end
            endcase
            chk("busy",     x.idx, {15'h0, ob}, {15'h0, x.b});
            chk("valid",    x.idx, {15'h0, ov}, {15'h0, x.v});
            chk("err",      x.idx, {15'h0, oe}, {15'h0, x.e});
            chk("data_out", x.idx, od, x.d[15:0]);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            mbusy[i] = 1'b1;
            mcnt[i] = 0;
            mdout[i] = 0;
        end
        req_all(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Writes during the clear must be lost; u0 is reset again at E50.
        for (int n = 1; n < 50; n++) req_all(1, 0, 3, 7);
        rst[0] = 1'b1;
        req_all(1, 0, 3, 7);
        rst[0] = 1'b0;
        for (int n = 0; n < 260; n++) req_all(n < 20, 0, 3, 7);

        // Cleared contents, then directed write/read cases.
        req_all(0, 1, 0, 0);
        req_all(0, 1, 11, 0);
        req_all(0, 1, 255, 0);
        req_all(0, 1, 3, 0);
        req_all(1, 0, 11, 37);
        req_all(1, 0, 11, 38);
        req_all(0, 1, 11, 0);
        req_all(0, 0, 0, 0);
        req_all(1, 1, 11, 45);
        req_all(0, 1, 11, 0);
        req_all(1, 0, 210, 99);
        req_all(0, 0, 0, 0);
        req_all(0, 1, 210, 0);
        req_all(1, 0, 199, 'h5A);
        req_all(0, 1, 199, 0);
        req_all(1, 0, 15, 'hBEEF);
        req_all(0, 1, 15, 0);
        for (int a = 0; a < 16; a++) req_all(1, 0, a, 'h1100 + a * 3);
        for (int a = 0; a < 16; a++) req_all(0, 1, a, 0);

        // Randomized traffic with occasional resets, biased towards interesting addresses.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                int sel;
                rst[i] = ($urandom_range(0, 999) == 0);
                wr[i]  = 1'($urandom_range(0, 1));
                rd[i]  = 1'($urandom_range(0, 1));
                sel    = $urandom_range(0, 3);
                case (sel)
                    0:       ad[i] = 8'($urandom_range(0, 15));
                    1:       ad[i] = 8'($urandom_range(190, 215));
                    2:       ad[i] = 8'($urandom_range(0, 255));
                    default: ad[i] = 8'd11;
                endcase
                di[i] = 16'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int n = 0; n < 3; n++) req_all(0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 0, 16'(sbq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
